ysyx_24080006_axi_arbiter: RTL and testbench
============================================

YSYX_24080006_AXI_ARBITER -- requirements
Module: ysyx_24080006_axi_arbiter

Interface
REQ-001 Parameter RR_EN, default 1'b0: 0 gives fixed LSU-over-IFU priority; 1 gives round-robin between LSU and IFU.
REQ-002 Port clock, input, 1: clock; all state updates on posedge.
REQ-003 Port reset, input, 1: reset, synchronous, active-high.
REQ-004 Port axi_ifu, ysyx_24080006_axi.slave, bundle: instruction-fetch requester, read channels only.
REQ-005 Port axi_lsu, ysyx_24080006_axi.slave, bundle: load/store requester, all five channels.
REQ-006 Port axi_mem, ysyx_24080006_axi.master, bundle: shared downstream memory/peripheral port.
REQ-007 Port grant_o, output, 2: current owner, encoded as arb_grant_e; debug and perf-counter use only.

Function
REQ-008 The block SHALL implement states IDLE, IFU_RD, LSU_RD and LSU_WR, held in a registered state variable.
REQ-009 IDLE, arbitration: requests are axi_ifu.arvalid, axi_lsu.arvalid and axi_lsu.awvalid.
  - LSU read or write request SHALL win when RR_EN=0.
  - When RR_EN=1 and both masters request, the master not granted last SHALL win.
  - A last-granted flag SHALL update on every grant; it resets to IFU, so LSU wins the first tie.
REQ-010 IDLE, LSU with awvalid and arvalid both high: the read SHALL be granted first (LSU_RD); the write waits.
REQ-011 IDLE: all axi_mem valid/ready outputs SHALL be 0, and all ready/valid outputs to both requesters SHALL be 0.
REQ-012 Grant SHALL be registered; forwarding begins the cycle after the request is first seen in IDLE (1-cycle arbitration latency). Requester valid SHALL stay high meanwhile, per AXI.
REQ-013 IFU_RD/LSU_RD:
  - AR and R channels of the owner SHALL connect combinationally to axi_mem: addr, len, size, burst, id, resp, data, last passed unmodified.
  - The non-owner SHALL see arready=0 and rvalid=0.
REQ-014 LSU_WR: AW, W and B channels of LSU SHALL connect combinationally to axi_mem; AW and W may handshake in any order or the same cycle.
REQ-015 Read state SHALL return to IDLE on the cycle after axi_mem rvalid&rready&rlast.
REQ-016 LSU_WR SHALL return to IDLE on the cycle after bvalid&bready; W beats before B SHALL not end the grant.
REQ-017 After completion, IDLE SHALL spend at least one cycle before a new grant (no back-to-back re-grant in the completion cycle).
REQ-018 Grant SHALL never change mid-transaction, regardless of requester valid deassertion or new requests.
REQ-019 axi_ifu AW/W/B outputs SHALL be tied off (awready=0, wready=0, bvalid=0). IFU awvalid SHALL be ignored and flagged by a simulation assertion.
REQ-020 Error responses (rresp/bresp != OKAY) SHALL be forwarded unchanged; the arbiter does not retry.
REQ-021 grant_o SHALL equal the state encoding: 0=IDLE, 1=IFU, 2=LSU_RD, 3=LSU_WR.

Reset
REQ-022 Reset SHALL force state IDLE, last-granted flag to IFU, grant_o=0, and all forwarded valid/ready outputs to 0 in the following cycle.
REQ-023 Reset mid-transaction SHALL abandon the transaction without draining; downstream is reset concurrently.

Structure
REQ-024 arb_state_e / arb_grant_e enum SHALL live in ysyx_24080006_pkg.
REQ-025 The block is one module with a 2-process FSM plus a combinational mux; no sub-module.
REQ-026 No FIFO or storage beyond state and last-granted flag.

Verification
REQ-027 IFU ar 0x3000_0000 len=0 alone -> grant_o=1 next cycle; mem araddr=0x3000_0000; rdata 0x0000_0413 reaches IFU; IDLE after rlast.
REQ-028 IFU and LSU arvalid same cycle, RR_EN=0 -> LSU_RD granted, IFU arready held 0 until LSU rlast, then IFU granted.
REQ-029 RR_EN=1, both request continuously for 4 transactions -> grants alternate LSU, IFU, LSU, IFU.
REQ-030 LSU write: aw 0x8000_0010, w 0xdead_beef strb=0xF; B delayed 5 cycles -> state held LSU_WR; IFU arvalid not accepted until cycle after bvalid&bready.
REQ-031 LSU awvalid+arvalid together -> read completes first, then write granted; mem never sees arvalid and awvalid high together.
REQ-032 Reset asserted during IFU 4-beat burst after beat 2 -> next cycle all axi_mem valids 0, grant_o=0; fresh LSU read afterwards completes normally.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the AXI arbiter slice: bus widths and arbiter state/grant encodings.
package ysyx_24080006_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IFU_RD = 2'd1,
        ARB_LSU_RD = 2'd2,
        ARB_LSU_WR = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_IFU    = 2'd1,
        GNT_LSU_RD = 2'd2,
        GNT_LSU_WR = 2'd3
    } arb_grant_e;

    // Grant encoding mirrors the state encoding one-to-one.
    function automatic arb_grant_e state_to_grant(input arb_state_e s);
        return arb_grant_e'(s);
    endfunction

endpackage

// File: rtl/ysyx_24080006_axi_if.sv
// AXI4 bundle (five channels) with requester-side (master) and responder-side (slave) views.
interface ysyx_24080006_axi;
    import ysyx_24080006_pkg::*;

    logic                    awvalid;
    logic                    awready;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [AXI_ID_W-1:0]     awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;

    logic                    wvalid;
    logic                    wready;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic [AXI_ID_W-1:0]     bid;

    logic                    arvalid;
    logic                    arready;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [AXI_ID_W-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;

    logic                    rvalid;
    logic                    rready;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [AXI_ID_W-1:0]     rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

endinterface

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Two-requester AXI arbiter: IFU (read only) and LSU (read/write) share one downstream port.
// One transaction owns the bus at a time; the grant is registered and held until completion.
module ysyx_24080006_axi_arbiter
    import ysyx_24080006_pkg::*;
#(
    parameter logic RR_EN = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_24080006_axi.slave         axi_ifu,
    ysyx_24080006_axi.slave         axi_lsu,
    ysyx_24080006_axi.master        axi_mem,
    output arb_grant_e              grant_o
);

    arb_state_e state_q, state_d;
    logic       last_lsu_q, last_lsu_d;
    logic       ifu_req, lsu_req, lsu_wins, rd_done, wr_done;
    logic       own_ifu, own_lsu_rd, own_lsu_wr;

    assign ifu_req = axi_ifu.arvalid;
    assign lsu_req = axi_lsu.arvalid | axi_lsu.awvalid;
    // Round-robin only breaks ties; with RR disabled the LSU always wins.
    assign lsu_wins = lsu_req & (~ifu_req | ~RR_EN | ~last_lsu_q);
    assign rd_done  = axi_mem.rvalid & axi_mem.rready & axi_mem.rlast;
    assign wr_done  = axi_mem.bvalid & axi_mem.bready;

    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        case (state_q)
            ARB_IDLE: begin
                if (lsu_wins) begin
                    // A pending LSU read goes ahead of its own pending write.
                    state_d    = axi_lsu.arvalid ? ARB_LSU_RD : ARB_LSU_WR;
                    last_lsu_d = 1'b1;
                end else if (ifu_req) begin
                    state_d    = ARB_IFU_RD;
                    last_lsu_d = 1'b0;
                end
            end
            ARB_IFU_RD, ARB_LSU_RD: if (rd_done) state_d = ARB_IDLE;
            ARB_LSU_WR:             if (wr_done) state_d = ARB_IDLE;
            default:                state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            last_lsu_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
        end
    end

    assign own_ifu    = (state_q == ARB_IFU_RD);
    assign own_lsu_rd = (state_q == ARB_LSU_RD);
    assign own_lsu_wr = (state_q == ARB_LSU_WR);
    assign grant_o    = state_to_grant(state_q);

    assign axi_mem.arvalid = (own_ifu & axi_ifu.arvalid) | (own_lsu_rd & axi_lsu.arvalid);
    assign axi_mem.araddr  = own_ifu ? axi_ifu.araddr  : axi_lsu.araddr;
    assign axi_mem.arid    = own_ifu ? axi_ifu.arid    : axi_lsu.arid;
    assign axi_mem.arlen   = own_ifu ? axi_ifu.arlen   : axi_lsu.arlen;
    assign axi_mem.arsize  = own_ifu ? axi_ifu.arsize  : axi_lsu.arsize;
    assign axi_mem.arburst = own_ifu ? axi_ifu.arburst : axi_lsu.arburst;
    assign axi_mem.rready  = (own_ifu & axi_ifu.rready) | (own_lsu_rd & axi_lsu.rready);

    assign axi_ifu.arready = own_ifu & axi_mem.arready;
    assign axi_ifu.rvalid  = own_ifu & axi_mem.rvalid;
    assign axi_ifu.rdata   = axi_mem.rdata;
    assign axi_ifu.rresp   = axi_mem.rresp;
    assign axi_ifu.rlast   = axi_mem.rlast;
    assign axi_ifu.rid     = axi_mem.rid;

    assign axi_lsu.arready = own_lsu_rd & axi_mem.arready;
    assign axi_lsu.rvalid  = own_lsu_rd & axi_mem.rvalid;
    assign axi_lsu.rdata   = axi_mem.rdata;
    assign axi_lsu.rresp   = axi_mem.rresp;
    assign axi_lsu.rlast   = axi_mem.rlast;
    assign axi_lsu.rid     = axi_mem.rid;

    // Write path belongs to the LSU only; AW and W may complete in either order.
    assign axi_mem.awvalid = own_lsu_wr & axi_lsu.awvalid;
    assign axi_mem.awaddr  = axi_lsu.awaddr;
    assign axi_mem.awid    = axi_lsu.awid;
    assign axi_mem.awlen   = axi_lsu.awlen;
    assign axi_mem.awsize  = axi_lsu.awsize;
    assign axi_mem.awburst = axi_lsu.awburst;
    assign axi_mem.wvalid  = own_lsu_wr & axi_lsu.wvalid;
    assign axi_mem.wdata   = axi_lsu.wdata;
    assign axi_mem.wstrb   = axi_lsu.wstrb;
    assign axi_mem.wlast   = axi_lsu.wlast;
    assign axi_mem.bready  = own_lsu_wr & axi_lsu.bready;

    assign axi_lsu.awready = own_lsu_wr & axi_mem.awready;
    assign axi_lsu.wready  = own_lsu_wr & axi_mem.wready;
    assign axi_lsu.bvalid  = own_lsu_wr & axi_mem.bvalid;
    assign axi_lsu.bresp   = axi_mem.bresp;
    assign axi_lsu.bid     = axi_mem.bid;

    assign axi_ifu.awready = 1'b0;
    assign axi_ifu.wready  = 1'b0;
    assign axi_ifu.bvalid  = 1'b0;
    assign axi_ifu.bresp   = 2'b00;
    assign axi_ifu.bid     = '0;

    logic unused_ifu_wr;
    assign unused_ifu_wr = ^{axi_ifu.awaddr, axi_ifu.awid, axi_ifu.awlen, axi_ifu.awsize,
                             axi_ifu.awburst, axi_ifu.wvalid, axi_ifu.wdata, axi_ifu.wstrb,
                             axi_ifu.wlast, axi_ifu.bready};

    // The fetch unit has no business issuing writes; catch it in simulation.
    a_ifu_no_write: assert property (@(posedge clock) disable iff (reset) !axi_ifu.awvalid);

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Directed bench for the AXI arbiter: fixed-priority instance plus a round-robin instance.
module tb_ysyx_24080006_axi_arbiter;
    import ysyx_24080006_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    arb_grant_e grant0, grant1;
    int         n_vec, n_err;

    always #5 clock = ~clock;

    ysyx_24080006_axi ifu0 ();
    ysyx_24080006_axi lsu0 ();
    ysyx_24080006_axi mem0 ();
    ysyx_24080006_axi ifu1 ();
    ysyx_24080006_axi lsu1 ();
    ysyx_24080006_axi mem1 ();

    ysyx_24080006_axi_arbiter #(.RR_EN(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .axi_ifu(ifu0), .axi_lsu(lsu0), .axi_mem(mem0), .grant_o(grant0)
    );
    ysyx_24080006_axi_arbiter #(.RR_EN(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .axi_ifu(ifu1), .axi_lsu(lsu1), .axi_mem(mem1), .grant_o(grant1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        {ifu0.awvalid, ifu0.awaddr, ifu0.awid, ifu0.awlen, ifu0.awsize, ifu0.awburst, ifu0.wvalid, ifu0.wdata,
         ifu0.wstrb, ifu0.wlast, ifu0.bready, ifu0.arvalid, ifu0.araddr, ifu0.arid, ifu0.arlen, ifu0.arsize,
         ifu0.arburst, ifu0.rready} = '0;
        {lsu0.awvalid, lsu0.awaddr, lsu0.awid, lsu0.awlen, lsu0.awsize, lsu0.awburst, lsu0.wvalid, lsu0.wdata,
         lsu0.wstrb, lsu0.wlast, lsu0.bready, lsu0.arvalid, lsu0.araddr, lsu0.arid, lsu0.arlen, lsu0.arsize,
         lsu0.arburst, lsu0.rready} = '0;
        {ifu1.awvalid, ifu1.awaddr, ifu1.awid, ifu1.awlen, ifu1.awsize, ifu1.awburst, ifu1.wvalid, ifu1.wdata,
         ifu1.wstrb, ifu1.wlast, ifu1.bready, ifu1.arvalid, ifu1.araddr, ifu1.arid, ifu1.arlen, ifu1.arsize,
         ifu1.arburst, ifu1.rready} = '0;
        {lsu1.awvalid, lsu1.awaddr, lsu1.awid, lsu1.awlen, lsu1.awsize, lsu1.awburst, lsu1.wvalid, lsu1.wdata,
         lsu1.wstrb, lsu1.wlast, lsu1.bready, lsu1.arvalid, lsu1.araddr, lsu1.arid, lsu1.arlen, lsu1.arsize,
         lsu1.arburst, lsu1.rready} = '0;
        {mem0.awready, mem0.wready, mem0.bvalid, mem0.bresp, mem0.bid, mem0.arready, mem0.rvalid, mem0.rdata,
         mem0.rresp, mem0.rlast, mem0.rid} = '0;
        {mem1.awready, mem1.wready, mem1.bvalid, mem1.bresp, mem1.bid, mem1.arready, mem1.rvalid, mem1.rdata,
         mem1.rresp, mem1.rlast, mem1.rid} = '0;

        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        settle();
        check("rst_grant0", grant0, 64'd0);
        check("rst_grant1", grant1, 64'd0);
        check("rst_mem_arvalid", mem0.arvalid, 64'd0);
        check("rst_mem_awvalid", mem0.awvalid, 64'd0);
        check("rst_mem_wvalid", mem0.wvalid, 64'd0);

        // Round-robin instance: both requesters hold arvalid continuously.
        ifu1.arvalid = 1'b1; ifu1.araddr = 32'h3000_0100; ifu1.rready = 1'b1;
        lsu1.arvalid = 1'b1; lsu1.araddr = 32'h8000_0100; lsu1.rready = 1'b1;
        mem1.arready = 1'b1; mem1.rlast = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_grant", grant1, (i % 2 == 0) ? 64'd2 : 64'd1);
            check("rr_araddr", mem1.araddr, (i % 2 == 0) ? 64'h8000_0100 : 64'h3000_0100);
            cycle();
            mem1.rvalid = 1'b1;
            settle();
            cycle();
            mem1.rvalid = 1'b0;
            settle();
            check("rr_idle", grant1, 64'd0);
        end
        ifu1.arvalid = 1'b0; lsu1.arvalid = 1'b0;

        // Lone IFU fetch.
        mem0.arready = 1'b1; ifu0.rready = 1'b1;
        ifu0.arvalid = 1'b1; ifu0.araddr = 32'h3000_0000; ifu0.arlen = 8'd0;
        settle();
        check("t1_idle_grant", grant0, 64'd0);
        check("t1_idle_arready", ifu0.arready, 64'd0);
        check("t1_idle_mem_arvalid", mem0.arvalid, 64'd0);
        cycle();
        check("t1_grant", grant0, 64'd1);
        check("t1_mem_araddr", mem0.araddr, 64'h3000_0000);
        check("t1_mem_arvalid", mem0.arvalid, 64'd1);
        check("t1_ifu_arready", ifu0.arready, 64'd1);
        cycle();
        ifu0.arvalid = 1'b0;
        mem0.rvalid = 1'b1; mem0.rdata = 32'h0000_0413; mem0.rlast = 1'b1;
        settle();
        check("t1_ifu_rvalid", ifu0.rvalid, 64'd1);
        check("t1_ifu_rdata", ifu0.rdata, 64'h0000_0413);
        check("t1_mem_rready", mem0.rready, 64'd1);
        cycle();
        mem0.rvalid = 1'b0; mem0.rlast = 1'b0;
        settle();
        check("t1_done_idle", grant0, 64'd0);

        // Simultaneous IFU/LSU reads under fixed priority.
        ifu0.arvalid = 1'b1; ifu0.araddr = 32'h3000_0004;
        lsu0.arvalid = 1'b1; lsu0.araddr = 32'h8000_0000; lsu0.arlen = 8'd1; lsu0.rready = 1'b1;
        cycle();
        check("t2_grant_lsu", grant0, 64'd2);
        check("t2_mem_araddr", mem0.araddr, 64'h8000_0000);
        check("t2_mem_arlen", mem0.arlen, 64'd1);
        check("t2_ifu_arready", ifu0.arready, 64'd0);
        check("t2_lsu_arready", lsu0.arready, 64'd1);
        cycle();
        lsu0.arvalid = 1'b0;
        mem0.rvalid = 1'b1; mem0.rdata = 32'h1111_1111; mem0.rlast = 1'b0;
        settle();
        check("t2_lsu_rvalid", lsu0.rvalid, 64'd1);
        check("t2_lsu_rdata", lsu0.rdata, 64'h1111_1111);
        check("t2_ifu_rvalid", ifu0.rvalid, 64'd0);
        cycle();
        mem0.rdata = 32'h2222_2222; mem0.rlast = 1'b1;
        settle();
        check("t2_mid_burst_grant", grant0, 64'd2);
        check("t2_mid_ifu_arready", ifu0.arready, 64'd0);
        cycle();
        mem0.rvalid = 1'b0; mem0.rlast = 1'b0;
        settle();
        check("t2_gap_idle", grant0, 64'd0);
        check("t2_gap_ifu_arready", ifu0.arready, 64'd0);
        cycle();
        check("t2_grant_ifu", grant0, 64'd1);
        check("t2_ifu_arready2", ifu0.arready, 64'd1);
        check("t2_mem_araddr_ifu", mem0.araddr, 64'h3000_0004);
        cycle();
        ifu0.arvalid = 1'b0;
        mem0.rvalid = 1'b1; mem0.rlast = 1'b1; mem0.rresp = 2'b10;
        settle();
        check("t2_rresp_fwd", ifu0.rresp, 64'd2);
        cycle();
        mem0.rvalid = 1'b0; mem0.rlast = 1'b0; mem0.rresp = 2'b00;

        // LSU write with a late B; a waiting IFU must not sneak in.
        lsu0.awvalid = 1'b1; lsu0.awaddr = 32'h8000_0010;
        lsu0.wvalid = 1'b1; lsu0.wdata = 32'hdead_beef; lsu0.wstrb = 4'hF; lsu0.wlast = 1'b1;
        lsu0.bready = 1'b1; mem0.awready = 1'b1; mem0.wready = 1'b1;
        cycle();
        check("t3_grant_wr", grant0, 64'd3);
        check("t3_mem_awaddr", mem0.awaddr, 64'h8000_0010);
        check("t3_mem_wdata", mem0.wdata, 64'hdead_beef);
        check("t3_mem_wstrb", mem0.wstrb, 64'hF);
        check("t3_lsu_awready", lsu0.awready, 64'd1);
        check("t3_lsu_wready", lsu0.wready, 64'd1);
        check("t3_mem_arvalid", mem0.arvalid, 64'd0);
        cycle();
        lsu0.awvalid = 1'b0; lsu0.wvalid = 1'b0;
        ifu0.arvalid = 1'b1; ifu0.araddr = 32'h3000_0008;
        settle();
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_grant", grant0, 64'd3);
            check("t3_hold_ifu_arready", ifu0.arready, 64'd0);
            cycle();
        end
        mem0.bvalid = 1'b1; mem0.bresp = 2'b10;
        settle();
        check("t3_lsu_bvalid", lsu0.bvalid, 64'd1);
        check("t3_bresp_fwd", lsu0.bresp, 64'd2);
        check("t3_mem_bready", mem0.bready, 64'd1);
        check("t3_b_ifu_arready", ifu0.arready, 64'd0);
        cycle();
        mem0.bvalid = 1'b0; mem0.bresp = 2'b00;
        settle();
        check("t3_after_b_idle", grant0, 64'd0);
        check("t3_after_b_ifu_arready", ifu0.arready, 64'd0);
        cycle();
        check("t3_ifu_granted", grant0, 64'd1);
        check("t3_ifu_arready", ifu0.arready, 64'd1);
        cycle();
        ifu0.arvalid = 1'b0;
        mem0.rvalid = 1'b1; mem0.rlast = 1'b1;
        cycle();
        mem0.rvalid = 1'b0; mem0.rlast = 1'b0;
        settle();
        check("t3_ifu_done", grant0, 64'd0);

        // LSU read and write pending together: read first, buses never overlap.
        lsu0.arvalid = 1'b1; lsu0.araddr = 32'h8000_0020; lsu0.arlen = 8'd0;
        lsu0.awvalid = 1'b1; lsu0.awaddr = 32'h8000_0024;
        lsu0.wvalid = 1'b1; lsu0.wdata = 32'hcafe_f00d;
        cycle();
        check("t4_grant_rd", grant0, 64'd2);
        check("t4_mem_arvalid", mem0.arvalid, 64'd1);
        check("t4_mem_awvalid", mem0.awvalid, 64'd0);
        check("t4_mem_wvalid", mem0.wvalid, 64'd0);
        check("t4_lsu_awready", lsu0.awready, 64'd0);
        cycle();
        lsu0.arvalid = 1'b0;
        mem0.rvalid = 1'b1; mem0.rlast = 1'b1;
        settle();
        check("t4_rd_mem_awvalid", mem0.awvalid, 64'd0);
        cycle();
        mem0.rvalid = 1'b0; mem0.rlast = 1'b0;
        settle();
        check("t4_gap_idle", grant0, 64'd0);
        check("t4_gap_awvalid", mem0.awvalid, 64'd0);
        cycle();
        check("t4_grant_wr", grant0, 64'd3);
        check("t4_wr_awvalid", mem0.awvalid, 64'd1);
        check("t4_wr_arvalid", mem0.arvalid, 64'd0);
        check("t4_wr_awaddr", mem0.awaddr, 64'h8000_0024);
        cycle();
        lsu0.awvalid = 1'b0; lsu0.wvalid = 1'b0;
        mem0.bvalid = 1'b1;
        cycle();
        mem0.bvalid = 1'b0;
        settle();
        check("t4_done_idle", grant0, 64'd0);

        // Reset in the middle of an IFU burst, then a clean LSU read.
        ifu0.arvalid = 1'b1; ifu0.araddr = 32'h3000_0040; ifu0.arlen = 8'd3;
        cycle();
        check("t5_grant_ifu", grant0, 64'd1);
        cycle();
        ifu0.arvalid = 1'b0;
        mem0.rvalid = 1'b1; mem0.rlast = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        settle();
        check("t5_pre_reset_grant", grant0, 64'd1);
        cycle();
        check("t5_reset_grant", grant0, 64'd0);
        check("t5_reset_arvalid", mem0.arvalid, 64'd0);
        check("t5_reset_rready", mem0.rready, 64'd0);
        check("t5_reset_ifu_rvalid", ifu0.rvalid, 64'd0);
        reset = 1'b0;
        mem0.rvalid = 1'b0; ifu0.arlen = 8'd0;
        lsu0.arvalid = 1'b1; lsu0.araddr = 32'h8000_0030;
        cycle();
        check("t5_lsu_grant", grant0, 64'd2);
        check("t5_lsu_araddr", mem0.araddr, 64'h8000_0030);
        cycle();
        lsu0.arvalid = 1'b0;
        mem0.rvalid = 1'b1; mem0.rlast = 1'b1; mem0.rdata = 32'h5555_aaaa;
        settle();
        check("t5_lsu_rvalid", lsu0.rvalid, 64'd1);
        check("t5_lsu_rdata", lsu0.rdata, 64'h5555_aaaa);
        cycle();
        mem0.rvalid = 1'b0; mem0.rlast = 1'b0;
        settle();
        check("t5_done_idle", grant0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
